// File: rtl/ysyx_24100029_pkg.sv
// ysyx_24100029 shared definitions.
// CSR lanes, WBU state and the commit-entry bundle.
package ysyx_24100029_pkg;

  localparam int XLEN   = 32;
  localparam int CSR_N  = 4;
  localparam int RIDX_W = 5;

  localparam int CSR_MEPC    = 0;
  localparam int CSR_MCAUSE  = 1;
  localparam int CSR_MTVEC   = 2;
  localparam int CSR_MSTATUS = 3;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic              wen;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   wdata;
    logic [CSR_N-1:0]  csr_wen;
    logic [XLEN-1:0]   csrs;
    logic              jump;
  } wb_entry_t;

  function automatic logic [XLEN-1:0] wb_sel_wdata(
    input logic            mem_ren,
    input logic [XLEN-1:0] lsu_rdata,
    input logic [XLEN-1:0] ex_result
  );
    return mem_ren ? lsu_rdata : ex_result;
  endfunction

  function automatic logic wb_gpr_wen(
    input logic              r_wen,
    input logic [RIDX_W-1:0] rd
  );
    return r_wen & (rd != '0);
  endfunction

endpackage

// File: rtl/ysyx_24100029_wbu.sv
// ysyx_24100029 write-back stage.
// One-entry commit register feeding GPR/CSR files and trace.
module ysyx_24100029_wbu
  import ysyx_24100029_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_last,
  output logic        ready_last,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        R_wen,
  input  logic [4:0]  rd,
  input  logic        mem_ren,
  input  logic [31:0] LSU_Rdata,
  input  logic [31:0] Ex_result,
  input  logic [3:0]  csr_wen,
  input  logic [31:0] csrs,
  input  logic        jump_flag,
  input  logic        commit_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  csr_we,
  output logic [31:0] csr_wdata,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic        commit_jump,
  output logic        wb_busy,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_fwd_data,
  output logic [63:0] instret
);

  wb_state_e state_q, state_d;
  wb_entry_t entry_q, entry_d;
  logic [63:0] instret_q, instret_d;

  logic full;
  logic capture;
  logic commit;

  assign full    = (state_q == WB_FULL);
  assign commit  = full & commit_ready;
  assign capture = valid_last & ready_last;

  assign ready_last = ~full | commit_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_EMPTY: begin
        if (capture) state_d = WB_FULL;
      end
      WB_FULL: begin
        if (commit && !capture) state_d = WB_EMPTY;
      end
      default: state_d = WB_EMPTY;
    endcase
  end

  // Result mux and x0 filter resolve here so commit is a pure drain.
  always_comb begin
    entry_d = entry_q;
    if (capture) begin
      entry_d.pc      = pc;
      entry_d.inst    = inst;
      entry_d.wen     = wb_gpr_wen(R_wen, rd);
      entry_d.rd      = rd;
      entry_d.wdata   = wb_sel_wdata(mem_ren, LSU_Rdata,
                                     Ex_result);
      entry_d.csr_wen = csr_wen;
      entry_d.csrs    = csrs;
      entry_d.jump    = jump_flag;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (commit) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= WB_EMPTY;
      entry_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      instret_q <= instret_d;
    end
  end

  assign rf_wen       = commit & entry_q.wen;
  assign rf_waddr     = entry_q.rd;
  assign rf_wdata     = entry_q.wdata;
  assign csr_we       = commit ? entry_q.csr_wen
                               : {CSR_N{1'b0}};
  assign csr_wdata    = entry_q.csrs;
  assign commit_valid = commit;
  assign commit_pc    = entry_q.pc;
  assign commit_inst  = entry_q.inst;
  assign commit_jump  = commit & entry_q.jump;

  assign wb_busy     = full;
  assign wb_rd       = (full & entry_q.wen) ? entry_q.rd
                                            : 5'd0;
  assign wb_fwd_data = entry_q.wdata;
  assign instret     = instret_q;

endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// Self-checking bench for ysyx_24100029_wbu.
// Vector table plus directed multi-cycle sequences.
module tb_ysyx_24100029_wbu;

  logic        clock;
  logic        reset;
  logic        valid_last;
  logic        ready_last;
  logic [31:0] pc, inst;
  logic        R_wen;
  logic [4:0]  rd;
  logic        mem_ren;
  logic [31:0] LSU_Rdata, Ex_result;
  logic [3:0]  csr_wen;
  logic [31:0] csrs;
  logic        jump_flag;
  logic        commit_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  csr_we;
  logic [31:0] csr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc, commit_inst;
  logic        commit_jump;
  logic        wb_busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_fwd_data;
  logic [63:0] instret;

  int asserts;
  int fails;

  ysyx_24100029_wbu dut (
    .clock        (clock),
    .reset        (reset),
    .valid_last   (valid_last),
    .ready_last   (ready_last),
    .pc           (pc),
    .inst         (inst),
    .R_wen        (R_wen),
    .rd           (rd),
    .mem_ren      (mem_ren),
    .LSU_Rdata    (LSU_Rdata),
    .Ex_result    (Ex_result),
    .csr_wen      (csr_wen),
    .csrs         (csrs),
    .jump_flag    (jump_flag),
    .commit_ready (commit_ready),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .commit_jump  (commit_jump),
    .wb_busy      (wb_busy),
    .wb_rd        (wb_rd),
    .wb_fwd_data  (wb_fwd_data),
    .instret      (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        r_wen;
    logic [4:0]  rd;
    logic        mem_ren;
    logic [31:0] lsu;
    logic [31:0] ex;
    logic [3:0]  csr_wen;
    logic [31:0] csrs;
    logic        jump;
    logic        e_rf_wen;
    logic [31:0] e_wdata;
    logic [4:0]  e_wb_rd;
    logic [3:0]  e_csr_we;
    logic        e_jump;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a_pc,
                       input logic        a_wen,
                       input logic [4:0]  a_rd,
                       input logic        a_mr,
                       input logic [31:0] a_lsu,
                       input logic [31:0] a_ex,
                       input logic [3:0]  a_cw,
                       input logic [31:0] a_cs,
                       input logic        a_j);
    valid_last = 1'b1;
    pc         = a_pc;
    inst       = a_pc ^ 32'h0000_0013;
    R_wen      = a_wen;
    rd         = a_rd;
    mem_ren    = a_mr;
    LSU_Rdata  = a_lsu;
    Ex_result  = a_ex;
    csr_wen    = a_cw;
    csrs       = a_cs;
    jump_flag  = a_j;
  endtask

  int   ncommit;
  logic [63:0] base;

  initial begin
    asserts = 0;
    fails   = 0;
    vecs[0] = '{32'h8000_0000, 32'h0, 1, 5'd5, 0,
                32'h0, 32'h1234, 4'h0, 32'h0, 0,
                1, 32'h1234, 5'd5, 4'h0, 0};
    vecs[1] = '{32'h8000_0004, 32'h0, 1, 5'd3, 1,
                32'hFFFF_FF80, 32'h8000_1000, 4'h0,
                32'h0, 0,
                1, 32'hFFFF_FF80, 5'd3, 4'h0, 0};
    vecs[2] = '{32'h8000_0008, 32'h0, 1, 5'd0, 0,
                32'h0, 32'h55, 4'h0, 32'h0, 0,
                0, 32'h55, 5'd0, 4'h0, 0};
    vecs[3] = '{32'h8000_000C, 32'h0, 0, 5'd7, 0,
                32'h0, 32'h77, 4'h0, 32'h0, 0,
                0, 32'h77, 5'd0, 4'h0, 0};
    vecs[4] = '{32'h8000_0010, 32'h0, 0, 5'd0, 0,
                32'h0, 32'h0, 4'b0100,
                32'h8000_0100, 0,
                0, 32'h0, 5'd0, 4'b0100, 0};
    vecs[5] = '{32'h8000_0014, 32'h0, 1, 5'd1, 1,
                32'h9, 32'h8000_0018, 4'h0, 32'h0, 1,
                1, 32'h9, 5'd1, 4'h0, 1};

    reset        = 1'b0;
    commit_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid_last = 1'b0;
    #12;
    chk("rst_ready", ready_last, 1);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_busy", wb_busy, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_instret", instret, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_cpc", commit_pc, 0);
    chk("rst_csr_we", csr_we, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].pc, vecs[i].r_wen, vecs[i].rd,
            vecs[i].mem_ren, vecs[i].lsu, vecs[i].ex,
            vecs[i].csr_wen, vecs[i].csrs,
            vecs[i].jump);
      chk($sformatf("v%0d_ready", i), ready_last, 1);
      tick();
      valid_last = 1'b0;
      chk($sformatf("v%0d_cvalid", i), commit_valid, 1);
      chk($sformatf("v%0d_rf_wen", i), rf_wen,
          vecs[i].e_rf_wen);
      chk($sformatf("v%0d_waddr", i), rf_waddr,
          vecs[i].rd);
      chk($sformatf("v%0d_wdata", i), rf_wdata,
          vecs[i].e_wdata);
      chk($sformatf("v%0d_wb_rd", i), wb_rd,
          vecs[i].e_wb_rd);
      chk($sformatf("v%0d_fwd", i), wb_fwd_data,
          vecs[i].e_wdata);
      chk($sformatf("v%0d_csr_we", i), csr_we,
          vecs[i].e_csr_we);
      chk($sformatf("v%0d_csr_wd", i), csr_wdata,
          vecs[i].csrs);
      chk($sformatf("v%0d_cjump", i), commit_jump,
          vecs[i].e_jump);
      chk($sformatf("v%0d_cpc", i), commit_pc,
          vecs[i].pc);
      chk($sformatf("v%0d_cinst", i), commit_inst,
          vecs[i].pc ^ 32'h13);
      chk($sformatf("v%0d_busy", i), wb_busy, 1);
      tick();
      chk($sformatf("v%0d_idle", i), commit_valid, 0);
      chk($sformatf("v%0d_instret", i), instret, i + 1);
    end

    base    = instret;
    ncommit = 0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h8000_0100 + 32'(4 * i), 1, 5'(10 + i),
            0, 0, 32'(i + 100), 0, 0, 0);
      chk($sformatf("b2b%0d_ready", i), ready_last, 1);
      tick();
      if (commit_valid) ncommit++;
      chk($sformatf("b2b%0d_waddr", i), rf_waddr,
          10 + i);
      chk($sformatf("b2b%0d_wdata", i), rf_wdata,
          100 + i);
    end
    valid_last = 1'b0;
    tick();
    chk("b2b_npulse", ncommit, 4);
    chk("b2b_idle", commit_valid, 0);
    chk("b2b_instret", instret, base + 4);

    base         = instret;
    commit_ready = 1'b0;
    drive(32'h8000_0200, 1, 5'd9, 0, 0,
          32'hAAAA, 0, 0, 0);
    tick();
    drive(32'h8000_0204, 1, 5'd12, 0, 0,
          32'hBBBB, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_ready", i), ready_last, 0);
      chk($sformatf("bp%0d_cvalid", i), commit_valid, 0);
      chk($sformatf("bp%0d_rf_wen", i), rf_wen, 0);
      chk($sformatf("bp%0d_wdata", i), rf_wdata,
          32'hAAAA);
      chk($sformatf("bp%0d_busy", i), wb_busy, 1);
      chk($sformatf("bp%0d_wb_rd", i), wb_rd, 9);
      chk($sformatf("bp%0d_instret", i), instret, base);
      tick();
    end
    commit_ready = 1'b1;
    #1;
    chk("bp_rel_ready", ready_last, 1);
    chk("bp_rel_cvalid", commit_valid, 1);
    chk("bp_rel_wdata", rf_wdata, 32'hAAAA);
    tick();
    valid_last = 1'b0;
    chk("bp_next_cvalid", commit_valid, 1);
    chk("bp_next_waddr", rf_waddr, 12);
    chk("bp_next_wdata", rf_wdata, 32'hBBBB);
    chk("bp_next_instret", instret, base + 1);
    tick();
    chk("bp_done_idle", commit_valid, 0);
    chk("bp_done_instret", instret, base + 2);

    drive(32'h8000_0300, 0, 0, 0, 0, 0,
          4'b0011, 32'hB, 1);
    tick();
    valid_last = 1'b0;
    chk("ecall_csr_we", csr_we, 4'b0011);
    chk("ecall_csr_wd", csr_wdata, 32'hB);
    chk("ecall_cjump", commit_jump, 1);
    chk("ecall_rf_wen", rf_wen, 0);
    tick();

    commit_ready = 1'b0;
    drive(32'h8000_0304, 1, 5'd4, 0, 0, 32'h44,
          4'b1000, 32'hC, 1);
    tick();
    valid_last = 1'b0;
    chk("pre_rst_busy", wb_busy, 1);
    chk("pre_rst_csr_we", csr_we, 0);
    reset = 1'b0;
    #1;
    commit_ready = 1'b1;
    #1;
    chk("mid_rst_busy", wb_busy, 0);
    chk("mid_rst_cvalid", commit_valid, 0);
    chk("mid_rst_csr_we", csr_we, 0);
    chk("mid_rst_rf_wen", rf_wen, 0);
    chk("mid_rst_jump", commit_jump, 0);
    chk("mid_rst_instret", instret, 0);
    chk("mid_rst_ready", ready_last, 1);
    chk("mid_rst_wb_rd", wb_rd, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_cvalid", commit_valid, 0);
    chk("post_rst_instret", instret, 0);
    chk("post_rst_busy", wb_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
